// File: rtl/adder_operand_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | adder_operand_sequencer_pkg                                          |
// | Shared widths and state encoding for the adder operand sequencer.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package adder_operand_sequencer_pkg;

  // Shared with the adder instance and its benches.
  localparam int DEFAULT_WIDTH = 64;
  localparam int LAT_W         = 4;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } seq_state_e;

endpackage : adder_operand_sequencer_pkg

`default_nettype wire

// File: rtl/adder_operand_sequencer_if.sv
// +----------------------------------------------------------------------+
// | adder_operand_sequencer_if                                           |
// | Operand stream, adder bus and result stream of the sequencer.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface adder_operand_sequencer_if
  import adder_operand_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) ();

  logic [WIDTH-1:0] op_data_i;
  logic             op_valid_i;
  logic             op_ready_o;
  logic [WIDTH-1:0] num1_o;
  logic [WIDTH-1:0] num2_o;
  logic [WIDTH-1:0] sum_i;
  logic [WIDTH-1:0] res_data_o;
  logic             res_carry_o;
  logic             res_ovf_o;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [CNT_W-1:0] pair_count_o;

  // Sequencer side.
  modport slave (
    input  op_data_i, op_valid_i, sum_i, res_ready_i,
    output op_ready_o, num1_o, num2_o, res_data_o, res_carry_o,
           res_ovf_o, res_valid_o, pair_count_o
  );

  // Producer / adder / consumer side.
  modport master (
    output op_data_i, op_valid_i, sum_i, res_ready_i,
    input  op_ready_o, num1_o, num2_o, res_data_o, res_carry_o,
           res_ovf_o, res_valid_o, pair_count_o
  );

endinterface : adder_operand_sequencer_if

`default_nettype wire

// File: rtl/adder_flags.sv
// +----------------------------------------------------------------------+
// | adder_flags                                                          |
// | Carry-out and signed overflow of A+B recovered from the MSBs only.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module adder_flags (
  input  logic a_msb_i,
  input  logic b_msb_i,
  input  logic s_msb_i,
  output logic carry_o,
  output logic ovf_o
);

  // The carry into the MSB is a^b^s there, which lets carry-out be
  // reconstructed without access to the adder's internal carry chain.
  assign carry_o = (a_msb_i & b_msb_i) | ((a_msb_i ^ b_msb_i) & ~s_msb_i);
  assign ovf_o   = (a_msb_i == b_msb_i) & (s_msb_i != a_msb_i);

endmodule : adder_flags

`default_nettype wire

// File: rtl/adder_operand_sequencer.sv
// +----------------------------------------------------------------------+
// | adder_operand_sequencer                                              |
// | Feeds an A/B operand pair to an external adder, samples the sum.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module adder_operand_sequencer
  import adder_operand_sequencer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ADDER_LAT = 0,
  parameter int CNT_W     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  adder_operand_sequencer_if.slave bus
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ADDER_LAT);

  seq_state_e       state_q;
  logic [WIDTH-1:0] num1_q;
  logic [WIDTH-1:0] num2_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_carry_q;
  logic             res_ovf_q;
  logic             res_valid_q;
  logic [CNT_W-1:0] pair_count_q;
  logic [CNT_W-1:0] pair_count_d;
  logic [LAT_W-1:0] wait_cnt_q;
  logic [LAT_W-1:0] wait_cnt_d;

  logic op_ready;
  logic op_hs;
  logic flag_carry;
  logic flag_ovf;

  assign op_ready     = (state_q == GET_A) || (state_q == GET_B);
  assign op_hs        = bus.op_valid_i & op_ready;
  assign pair_count_d = pair_count_q + 1'b1;
  assign wait_cnt_d   = wait_cnt_q - 1'b1;

  adder_flags u_flags (
    .a_msb_i (num1_q[WIDTH-1]),
    .b_msb_i (num2_q[WIDTH-1]),
    .s_msb_i (bus.sum_i[WIDTH-1]),
    .carry_o (flag_carry),
    .ovf_o   (flag_ovf)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= GET_A;
      num1_q       <= '0;
      num2_q       <= '0;
      res_data_q   <= '0;
      res_carry_q  <= 1'b0;
      res_ovf_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      pair_count_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      case (state_q)
        GET_A: begin
          if (op_hs) begin
            num1_q  <= bus.op_data_i;
            state_q <= GET_B;
          end
        end
        GET_B: begin
          if (op_hs) begin
            num2_q     <= bus.op_data_i;
            wait_cnt_q <= LAT_INIT;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          // Operands have been stable on the adder for ADDER_LAT+1 cycles here.
          if (wait_cnt_q == '0) begin
            res_data_q  <= bus.sum_i;
            res_carry_q <= flag_carry;
            res_ovf_q   <= flag_ovf;
            res_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        OUT: begin
          if (bus.res_ready_i) begin
            res_valid_q  <= 1'b0;
            pair_count_q <= pair_count_d;
            state_q      <= GET_A;
          end
        end
        default: state_q <= GET_A;
      endcase
    end
  end

  assign bus.op_ready_o   = op_ready;
  assign bus.num1_o       = num1_q;
  assign bus.num2_o       = num2_q;
  assign bus.res_data_o   = res_data_q;
  assign bus.res_carry_o  = res_carry_q;
  assign bus.res_ovf_o    = res_ovf_q;
  assign bus.res_valid_o  = res_valid_q;
  assign bus.pair_count_o = pair_count_q;

endmodule : adder_operand_sequencer

`default_nettype wire

// File: tb/tb_adder_operand_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_adder_operand_sequencer                                           |
// | Directed bench: one sequencer with ADDER_LAT=0/CNT_W=2, one with 3/16.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_adder_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] op_data = '0;
  logic        op_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic        sel = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adder_operand_sequencer_if #(.WIDTH(64), .CNT_W(2))  if0 ();
  adder_operand_sequencer_if #(.WIDTH(64), .CNT_W(16)) if3 ();

  assign if0.op_data_i   = op_data;
  assign if0.op_valid_i  = op_valid & ~sel;
  assign if0.res_ready_i = res_ready & ~sel;
  assign if0.sum_i       = if0.num1_o + if0.num2_o;

  assign if3.op_data_i   = op_data;
  assign if3.op_valid_i  = op_valid & sel;
  assign if3.res_ready_i = res_ready & sel;
  assign if3.sum_i       = if3.num1_o + if3.num2_o;

  adder_operand_sequencer #(.WIDTH(64), .ADDER_LAT(0), .CNT_W(2)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if0.slave)
  );

  adder_operand_sequencer #(.WIDTH(64), .ADDER_LAT(3), .CNT_W(16)) dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if3.slave)
  );

  logic        w_ready, w_valid, w_carry, w_ovf;
  logic [63:0] w_data, w_num1, w_num2, w_cnt;
  assign w_ready = sel ? if3.op_ready_o  : if0.op_ready_o;
  assign w_valid = sel ? if3.res_valid_o : if0.res_valid_o;
  assign w_carry = sel ? if3.res_carry_o : if0.res_carry_o;
  assign w_ovf   = sel ? if3.res_ovf_o   : if0.res_ovf_o;
  assign w_data  = sel ? if3.res_data_o  : if0.res_data_o;
  assign w_num1  = sel ? if3.num1_o      : if0.num1_o;
  assign w_num2  = sel ? if3.num2_o      : if0.num2_o;
  assign w_cnt   = sel ? 64'(if3.pair_count_o) : 64'(if0.pair_count_o);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d);
    int n;
    n = 0;
    op_data  = d;
    op_valid = 1'b1;
    while (!w_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("op_ready_timeout", 64'(w_ready), 64'd1);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_valid(input int exp_lat, input string tag);
    int c;
    c = 0;
    while (!w_valid && c < 20) begin
      tick();
      c++;
    end
    check(tag, 64'(c), 64'(exp_lat));
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic pair(input logic [63:0] a, input logic [63:0] b, input int lat,
                      input logic [63:0] exp_s, input logic exp_c, input logic exp_v);
    send_word(a);
    send_word(b);
    wait_valid(lat + 1, "latency");
    check("sum", w_data, exp_s);
    check("carry", 64'(w_carry), 64'(exp_c));
    check("ovf", 64'(w_ovf), 64'(exp_v));
  endtask

  initial begin
    logic [63:0] a, b;

    // Asynchronous reset before the first clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_num1", if0.num1_o, 64'd0);
    check("rst_num2", if0.num2_o, 64'd0);
    check("rst_data", if0.res_data_o, 64'd0);
    check("rst_flags", {62'd0, if0.res_carry_o, if0.res_ovf_o}, 64'd0);
    check("rst_valid", 64'(if0.res_valid_o), 64'd0);
    check("rst_cnt", 64'(if0.pair_count_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    check("ready_after_rst", 64'(w_ready), 64'd1);

    // res_ready outside OUT must not count.
    res_ready = 1'b1;
    tick();
    tick();
    res_ready = 1'b0;
    check("ready_idle_no_count", w_cnt, 64'd0);

    // ADDER_LAT=0 directed pairs.
    pair(64'd1, 64'd1, 0, 64'd2, 1'b0, 1'b0);
    check("op_ready_in_out", 64'(w_ready), 64'd0);
    accept();
    check("cnt_1", w_cnt, 64'd1);
    check("ready_after_accept", 64'(w_ready), 64'd1);

    pair(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0, 1'b1, 1'b0);
    accept();
    check("num1_held", w_num1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("num2_held", w_num2, 64'd1);

    pair(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    accept();
    pair(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 64'd0, 1'b1, 1'b1);
    accept();
    check("cnt_4_wraps_0", w_cnt, 64'd0);

    // Backpressure with a pending extra operand.
    pair(64'd5, 64'd10, 0, 64'd15, 1'b0, 1'b0);
    op_data  = 64'hDEAD;
    op_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_data", w_data, 64'd15);
      check("bp_valid", 64'(w_valid), 64'd1);
      check("bp_op_ready", 64'(w_ready), 64'd0);
      check("bp_num1", w_num1, 64'd5);
    end
    accept();
    check("cnt_5_wrap", w_cnt, 64'd1);
    send_word(64'hDEAD);
    check("next_word_is_A", w_num1, 64'hDEAD);
    send_word(64'd2);
    wait_valid(1, "latency_after_bp");
    check("sum_after_bp", w_data, 64'hDEAF);
    accept();
    check("cnt_6", w_cnt, 64'd2);

    // ADDER_LAT=3 sweep of powers of 59 and 73.
    sel = 1'b1;
    tick();
    a = 64'd1;
    for (int i = 0; i < 4; i++) begin
      b = 64'd1;
      for (int j = 0; j < 4; j++) begin
        pair(a, b, 3, a + b, 1'b0, 1'b0);
        accept();
        b = b * 64'd73;
      end
      a = a * 64'd59;
    end
    check("sweep_cnt", w_cnt, 64'd16);

    // Asynchronous reset while waiting on the adder.
    send_word(64'h100);
    send_word(64'h200);
    tick();
    #2 rst = 1'b1;
    #1;
    check("wait_rst_num1", if3.num1_o, 64'd0);
    check("wait_rst_num2", if3.num2_o, 64'd0);
    check("wait_rst_data", if3.res_data_o, 64'd0);
    check("wait_rst_valid", 64'(if3.res_valid_o), 64'd0);
    check("wait_rst_cnt", 64'(if3.pair_count_o), 64'd0);
    check("wait_rst_cnt_dut0", 64'(if0.pair_count_o), 64'd0);
    check("wait_rst_state_get_a", 64'(if3.op_ready_o), 64'd1);
    @(negedge clk) rst = 1'b0;
    tick();
    pair(64'd3, 64'd4, 3, 64'd7, 1'b0, 1'b0);
    check("post_rst_num1", w_num1, 64'd3);
    accept();
    check("post_rst_cnt", w_cnt, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_adder_operand_sequencer

`default_nettype wire
